// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: multiplier FSM encoding and latency.
package mips_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_LATENCY = MULT_WIDTH + 1;

  // Encodings kept as plain constants so older netlists that probe state still match
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_BUSY = 2'd1;
  localparam logic [1:0] STATE_FIX  = 2'd2;
  localparam logic [1:0] STATE_DONE = 2'd3;

endpackage

// File: rtl/mult_abs.sv
// Combinational magnitude/sign extraction for one multiplier operand.
module mult_abs #(
  parameter int WIDTH = 32
) (
  input  logic             signedOp,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  // The most negative value negates to itself, which read as unsigned is exactly 2^(WIDTH-1)
  assign neg = signedOp & value[WIDTH-1];
  assign mag = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential MULT/MULTU unit: fixed WIDTH+1 cycle latency by default,
// optional early termination when MULT_EARLY_TERM_EN is defined.
module seq_multiplier
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multstartE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             pve,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               negResult;

  logic [WIDTH-1:0]   magA, magB;
  logic               negA, negB;
  logic [WIDTH:0]     partialSum;
  logic [2*WIDTH-1:0] stepAcc;

  mult_abs #(.WIDTH(WIDTH)) absA (
    .signedOp (signedE),
    .value    (srcaE),
    .mag      (magA),
    .neg      (negA)
  );

  mult_abs #(.WIDTH(WIDTH)) absB (
    .signedOp (signedE),
    .value    (srcbE),
    .mag      (magB),
    .neg      (negB)
  );

  // Carry out of the upper-half add becomes the MSB after the right shift
  assign partialSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign stepAcc    = {partialSum, acc[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] remShift;
  assign remShift = LAST_STEP - count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STATE_IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      negResult <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        STATE_IDLE, STATE_DONE: begin
          if (multstartE) begin
            mcand     <= magA;
            mplier    <= magB;
            negResult <= negA ^ negB;
            acc       <= '0;
            count     <= '0;
            state     <= STATE_BUSY;
          end
        end
        STATE_BUSY: begin
          acc    <= stepAcc;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= STATE_FIX;
          end
`ifdef MULT_EARLY_TERM_EN
          // Remaining multiplier bits are zero: collapse the outstanding shifts into this step
          else if (mplier[WIDTH-1:1] == '0) begin
            acc   <= stepAcc >> remShift;
            state <= STATE_FIX;
          end
`endif
        end
        STATE_FIX: begin
          {hi, lo} <= negResult ? (~acc + 1'b1) : acc;
          state    <= STATE_DONE;
        end
      endcase
    end
  end

  assign busy = (state == STATE_BUSY) || (state == STATE_FIX);
  assign pve  = (state == STATE_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table for results/latency plus
// hand-written sequences for ignored starts, restart from DONE and mid-op reset.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        multstartE;
  logic        signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        pve;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .multstartE (multstartE),
    .signedE    (signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hi         (hi),
    .lo         (lo),
    .pve        (pve),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vector_t;

  vector_t vectors[10];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Start on the edge after the next negedge; latency counts edges until pve is seen (-1 on timeout)
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               output int latency);
    @(negedge clk);
    signedE    = sgn;
    srcaE      = a;
    srcbE      = b;
    multstartE = 1'b1;
    @(posedge clk);
    #1;
    multstartE = 1'b0;
    latency = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (pve) begin
        latency = n;
        break;
      end
    end
  endtask

  int  lat;
  int  lateFlag;
  logic [31:0] oldHi, oldLo;

  initial begin
    vectors[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vectors[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vectors[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vectors[3] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vectors[4] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    vectors[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vectors[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
    vectors[7] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vectors[8] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vectors[9] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

    reset      = 1'b1;
    multstartE = 1'b0;
    signedE    = 1'b0;
    srcaE      = '0;
    srcbE      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetHi",   {32'h0, hi}, 64'h0);
    checkOutput("resetLo",   {32'h0, lo}, 64'h0);
    checkOutput("resetPve",  {63'h0, pve}, 64'h0);
    checkOutput("resetBusy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].sgn, vectors[i].a, vectors[i].b, lat);
      checkOutput($sformatf("vec%0d.product", i), {hi, lo}, {vectors[i].expHi, vectors[i].expLo});
`ifdef MULT_EARLY_TERM_EN
      checkOutput($sformatf("vec%0d.latencyInRange", i), 64'((lat >= 2) && (lat <= 33)), 64'h1);
`else
      checkOutput($sformatf("vec%0d.latency", i), 64'(lat), 64'd33);
`endif
    end

    // Second start at cycle 10 must be ignored; multiplier MSB set keeps it BUSY in both builds
    @(negedge clk);
    signedE    = 1'b0;
    srcaE      = 32'h0000_0006;
    srcbE      = 32'h8000_0007;
    multstartE = 1'b1;
    @(posedge clk);
    #1;
    multstartE = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 10) begin
        srcaE      = 32'd100;
        srcbE      = 32'd100;
        multstartE = 1'b1;
      end
      @(posedge clk);
      #1;
      multstartE = 1'b0;
      if (n == 10) checkOutput("ignoreBusyHeld", {63'h0, busy}, 64'h1);
      if (pve) begin
        lat = n;
        break;
      end
    end
    checkOutput("ignoreProduct", {hi, lo}, 64'h0000_0003_0000_002A);
    checkOutput("ignoreLatency", 64'(lat), 64'd33);

    // Restart from DONE: pve drops after the start edge, hi/lo hold until the new result
    oldHi = hi;
    oldLo = lo;
    @(negedge clk);
    signedE    = 1'b1;
    srcaE      = 32'hFFFF_FFFD;
    srcbE      = 32'h8000_0007;
    multstartE = 1'b1;
    @(posedge clk);
    #1;
    multstartE = 1'b0;
    checkOutput("restartPveLow", {63'h0, pve}, 64'h0);
    checkOutput("restartBusy",   {63'h0, busy}, 64'h1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("restartHoldHiLo", {hi, lo}, {oldHi, oldLo});
    lat = -1;
    for (int n = 6; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (pve) begin
        lat = n;
        break;
      end
    end
    // -3 * -2147483641 = 6442450923 = 0x1_7FFF_FFEB
    checkOutput("restartProduct", {hi, lo}, 64'h0000_0001_7FFF_FFEB);
    checkOutput("restartLatency", 64'(lat), 64'd33);

    // Reset at cycle 15 aborts the operation and clears the result registers
    @(negedge clk);
    signedE    = 1'b0;
    srcaE      = 32'd5;
    srcbE      = 32'h8000_0001;
    multstartE = 1'b1;
    @(posedge clk);
    #1;
    multstartE = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortPve",  {63'h0, pve}, 64'h0);
    checkOutput("abortBusy", {63'h0, busy}, 64'h0);
    checkOutput("abortHiLo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    lateFlag = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (pve || busy) lateFlag = 1;
    end
    checkOutput("abortNoLatePve", 64'(lateFlag), 64'h0);

    // Reset wins over a simultaneous start
    applyStimulus(1'b0, 32'd9, 32'd9, lat);
    checkOutput("preResetResult", {hi, lo}, 64'd81);
    @(negedge clk);
    reset      = 1'b1;
    multstartE = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetPriorityBusy", {63'h0, busy}, 64'h0);
    checkOutput("resetPriorityHiLo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset      = 1'b0;
    multstartE = 1'b0;

    // Small-multiplier latency: short with early termination, full otherwise
    applyStimulus(1'b0, 32'd5, 32'd0, lat);
    checkOutput("zeroProduct", {hi, lo}, 64'h0);
`ifdef MULT_EARLY_TERM_EN
    checkOutput("zeroLatency", 64'(lat), 64'd2);
`else
    checkOutput("zeroLatency", 64'(lat), 64'd33);
`endif
    applyStimulus(1'b0, 32'd5, 32'd3, lat);
    checkOutput("fifteenProduct", {hi, lo}, 64'd15);
`ifdef MULT_EARLY_TERM_EN
    checkOutput("fifteenLatency", 64'(lat), 64'd3);
`else
    checkOutput("fifteenLatency", 64'(lat), 64'd33);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
